// File: rtl/sha_pkg.sv
// Shared SHA types, message-schedule helper functions and round-count constants
// used by the round controller and its message scheduler.
package sha;

    typedef enum logic [2:0] {
        SHA1   = 3'd0,
        SHA224 = 3'd1,
        SHA256 = 3'd2,
        SHA384 = 3'd3,
        SHA512 = 3'd4
    } mode_t;

    // One 1024-bit block seen either as 16 x 64-bit words or as 32 x 32-bit words.
    // Word 0 is the most significant word; 32-bit modes only use w32[15:0].
    typedef union packed {
        logic [15:0][63:0] w64;
        logic [31:0][31:0] w32;
    } msg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } ctrl_state_t;

    localparam logic [6:0] ROUNDS_64 = 7'd64;
    localparam logic [6:0] ROUNDS_80 = 7'd80;

    function automatic logic mode_ok(input mode_t m);
        return (m == SHA1) || (m == SHA224) || (m == SHA256) ||
               (m == SHA384) || (m == SHA512);
    endfunction

    function automatic logic is_64(input mode_t m);
        return (m == SHA384) || (m == SHA512);
    endfunction

    function automatic logic [6:0] rounds(input mode_t m);
        return ((m == SHA224) || (m == SHA256)) ? ROUNDS_64 : ROUNDS_80;
    endfunction

    function automatic logic [31:0] rotl1_32(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [31:0] delta0_32(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] delta1_32(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [63:0] delta0_64(input logic [63:0] x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
    endfunction

    function automatic logic [63:0] delta1_64(input logic [63:0] x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
    endfunction

endpackage

// File: rtl/sha_round_ctrl_if.sv
// Block-input and round-output signal bundle between a block source / compression
// datapath (master) and the round controller (slave).
interface sha_round_ctrl_if;

    sha::mode_t  mode;
    logic        blk_valid;
    logic        blk_ready;
    sha::msg_t   blk;
    logic        round_valid;
    logic        core_ready;
    logic [6:0]  round_idx;
    logic [63:0] round_w;
    logic        fin_valid;
    logic        busy;

    modport master (
        output mode, blk_valid, blk, core_ready,
        input  blk_ready, round_valid, round_idx, round_w, fin_valid, busy
    );

    modport slave (
        input  mode, blk_valid, blk, core_ready,
        output blk_ready, round_valid, round_idx, round_w, fin_valid, busy
    );

endinterface

// File: rtl/sha_msg_sched.sv
// 16-word sliding message-schedule window; window[0] is the current W_t and each
// shift appends the next expanded word W_(t+16) at the top.
module sha_msg_sched
    import sha::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        shift,
    input  mode_t       mode,
    input  msg_t        blk,
    output logic [63:0] w0
);

    logic [63:0] window_reg  [16];
    logic [63:0] window_next [16];
    logic [63:0] load_word   [16];
    logic [63:0] shift_word  [16];
    logic [63:0] new_word;

    // window_reg[k] holds W_(t+k), so the taps below are relative to t+16.
    always_comb begin
        new_word = '0;
        if (mode == SHA1) begin
            new_word = {32'd0, rotl1_32(window_reg[13][31:0] ^ window_reg[8][31:0] ^
                                        window_reg[2][31:0]  ^ window_reg[0][31:0])};
        end else if (is_64(mode)) begin
            new_word = delta1_64(window_reg[14]) + window_reg[9] +
                       delta0_64(window_reg[1]) + window_reg[0];
        end else begin
            new_word = {32'd0, delta1_32(window_reg[14][31:0]) + window_reg[9][31:0] +
                               delta0_32(window_reg[1][31:0]) + window_reg[0][31:0]};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_win
            assign load_word[gi] = is_64(mode) ? blk.w64[15-gi] : {32'd0, blk.w32[15-gi]};
            if (gi == 15) begin : g_top
                assign shift_word[gi] = new_word;
            end else begin : g_mid
                assign shift_word[gi] = window_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        window_next = window_reg;
        if (load) begin
            window_next = load_word;
        end else if (shift) begin
            window_next = shift_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                window_reg[i] <= '0;
            end
        end else begin
            window_reg <= window_next;
        end
    end

    assign w0 = window_reg[0];

endmodule

// File: rtl/sha_round_ctrl.sv
// SHA round sequencer: accepts a message block, issues one schedule word per round
// under core_ready backpressure, then pulses fin_valid once before going idle.
module sha_round_ctrl
    import sha::*;
(
    input  logic clk,
    input  logic rst,
    sha_round_ctrl_if.slave bus
);

    ctrl_state_t state_reg, state_next;
    logic [6:0]  t_reg, t_next;
    mode_t       mode_reg, mode_next;

    logic        blk_ready;
    logic        round_valid;
    logic        fin_valid;
    logic        busy;
    logic        accept;
    logic        round_hs;
    mode_t       sched_mode;
    logic [63:0] w0;

    assign accept   = bus.blk_valid & blk_ready;
    assign round_hs = round_valid & bus.core_ready;

    always_comb begin
        state_next  = state_reg;
        t_next      = t_reg;
        mode_next   = mode_reg;
        blk_ready   = 1'b0;
        round_valid = 1'b0;
        fin_valid   = 1'b0;
        busy        = 1'b1;
        unique case (state_reg)
            ST_IDLE: begin
                busy      = 1'b0;
                // Held low during reset so readiness first appears after rst falls.
                blk_ready = mode_ok(bus.mode) & ~rst;
                if (bus.blk_valid && blk_ready) begin
                    state_next = ST_ROUND;
                    mode_next  = bus.mode;
                    t_next     = '0;
                end
            end
            ST_ROUND: begin
                round_valid = 1'b1;
                if (bus.core_ready) begin
                    if (t_reg == rounds(mode_reg) - 7'd1) begin
                        state_next = ST_FINAL;
                        t_next     = '0;
                    end else begin
                        t_next = t_reg + 7'd1;
                    end
                end
            end
            ST_FINAL: begin
                fin_valid  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                t_next     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            t_reg     <= '0;
            mode_reg  <= SHA256;
        end else begin
            state_reg <= state_next;
            t_reg     <= t_next;
            mode_reg  <= mode_next;
        end
    end

    // The scheduler must see the live mode while loading, the latched one afterwards.
    assign sched_mode = (state_reg == ST_IDLE) ? bus.mode : mode_reg;

    sha_msg_sched u_sched (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (round_hs),
        .mode  (sched_mode),
        .blk   (bus.blk),
        .w0    (w0)
    );

    assign bus.blk_ready   = blk_ready;
    assign bus.round_valid = round_valid;
    assign bus.fin_valid   = fin_valid;
    assign bus.busy        = busy;
    assign bus.round_idx   = t_reg;
    assign bus.round_w     = w0;

endmodule
